pixel_delay_line: RTL and testbench



---
 rtl/pixel_delay_line_pkg.sv | 20 ++
 rtl/pixel_delay_line_line_ram.sv | 41 ++++
 rtl/pixel_delay_line.sv | 154 +++++++++++++++
 tb/tb_pixel_delay_line.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_delay_line_pkg.sv
// Shared definitions for the pixel_delay_line slice and the windowed filter
// blocks that sit alongside it in the camera video path.
//   DEF_DATA_W  : default pixel width (RGB888)
//   DEF_MAX_W   : default maximum line width
//   pixel_t     : pixel word at the default width
//   total_delay : delay in accepted samples for a rows x width + cols window
package pixel_delay_line_pkg;

    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_MAX_W  = 1024;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

    function automatic int unsigned total_delay(input int unsigned rows,
                                                input int unsigned cols,
                                                input int unsigned width);
        return rows * width + cols;
    endfunction

endpackage

// File: rtl/pixel_delay_line_line_ram.sv
// One line buffer: simple dual-port RAM, one write port and one synchronous
// read port, DATA_W x DEPTH. A read of the address being written returns the
// old contents. The read register holds while re is low.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable (updates rdata on the next edge)
//   raddr : read address
//   rdata : registered read data
module line_ram
    import pixel_delay_line_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_MAX_W,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pixel_delay_line.sv
// Delays each accepted pixel by ROW_DLY lines of the latched width W plus
// COL_DLY pixels (D = ROW_DLY*W + COL_DLY accepts), with per-frame priming,
// output-valid flag, registered bypass and runtime line width.
//   clk       : pixel clock
//   rst_n     : synchronous active-low reset
//   line_w    : active line width, latched on an accepted sof (0 or >MAX_W -> MAX_W)
//   bypass    : 1 = pix_out/out_valid follow pix_in/pix_valid one cycle later
//   sof       : start of frame, only meaningful with pix_valid
//   pix_valid : pixel accepted this cycle
//   pix_in    : input pixel
//   pix_out   : delayed pixel (held on non-accept cycles in normal mode)
//   out_valid : pix_out carries a primed, delayed sample
module pixel_delay_line
    import pixel_delay_line_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MAX_W   = DEF_MAX_W,
    parameter int unsigned ROW_DLY = 5,
    parameter int unsigned COL_DLY = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [$clog2(MAX_W):0] line_w,
    input  logic                   bypass,
    input  logic                   sof,
    input  logic                   pix_valid,
    input  logic [DATA_W-1:0]      pix_in,
    output logic [DATA_W-1:0]      pix_out,
    output logic                   out_valid
);

    localparam int unsigned AW   = $clog2(MAX_W);
    localparam int unsigned WW   = AW + 1;
    localparam int unsigned DMAX = ROW_DLY * MAX_W + COL_DLY;
    localparam int unsigned CW   = $clog2(DMAX + 2);

    logic              accept, frame_start;
    logic [WW-1:0]     w_d, w_q, eff_w, addr_inc;
    logic [AW-1:0]     ptr_d, ptr_q, wr_addr, rd_addr;
    logic [CW-1:0]     cnt_d, cnt_q, idx, dly;
    logic [DATA_W-1:0] pix_out_d, pix_out_q, src, tap;
    logic              out_valid_d, out_valid_q;

    always_comb begin
        accept      = pix_valid;
        frame_start = pix_valid & sof;

        eff_w = w_q;
        if (frame_start) begin
            eff_w = (line_w == '0 || line_w > WW'(MAX_W)) ? WW'(MAX_W) : line_w;
        end

        // Rows read one address ahead of the write so the registered read
        // lands in time to feed the next row / column stage on the following
        // accept; the extra cycle of the RAM read is absorbed this way.
        wr_addr  = frame_start ? '0 : ptr_q;
        addr_inc = {1'b0, wr_addr} + WW'(1);
        rd_addr  = (addr_inc >= eff_w) ? '0 : addr_inc[AW-1:0];

        dly = CW'(total_delay(ROW_DLY, COL_DLY, 32'(eff_w)));
        idx = frame_start ? '0 : cnt_q;

        w_d         = w_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pix_out_d   = pix_out_q;
        out_valid_d = 1'b0;

        if (accept) begin
            w_d   = eff_w;
            ptr_d = rd_addr;
            cnt_d = (idx >= dly) ? dly : idx + CW'(1);
        end

        if (bypass) begin
            pix_out_d   = pix_in;
            out_valid_d = pix_valid;
        end else if (accept) begin
            pix_out_d   = tap;
            out_valid_d = (idx >= dly);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q         <= WW'(MAX_W);
            ptr_q       <= '0;
            cnt_q       <= '0;
            pix_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            w_q         <= w_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pix_out_q   <= pix_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // row_out[k] is the registered output of row k-1; row_out[0] is the input.
    logic [DATA_W-1:0] row_out [ROW_DLY+1];
    assign row_out[0] = pix_in;

    for (genvar k = 0; k < ROW_DLY; k++) begin : g_row
        logic [DATA_W-1:0] ram_rd, fwd_d, fwd_q;

        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_W)
        ) u_line_ram (
            .clk   (clk),
            .we    (accept),
            .waddr (wr_addr),
            .wdata (row_out[k]),
            .re    (accept),
            .raddr (rd_addr),
            .rdata (ram_rd)
        );

        // With W=1 the read-ahead address equals the write address, so the
        // RAM would return the previous sample; take the write data instead.
        always_comb fwd_d = accept ? row_out[k] : fwd_q;
        always_ff @(posedge clk) fwd_q <= fwd_d;

        assign row_out[k+1] = (w_q == WW'(1)) ? fwd_q : ram_rd;
    end

    assign src = row_out[ROW_DLY];

    if (COL_DLY == 0) begin : g_no_col
        assign tap = src;
    end else begin : g_col
        logic [DATA_W-1:0] col_d [COL_DLY];
        logic [DATA_W-1:0] col_q [COL_DLY];

        always_comb begin
            col_d = col_q;
            if (accept) begin
                col_d[0] = src;
                for (int unsigned i = 1; i < COL_DLY; i++) begin
                    col_d[i] = col_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) col_q <= col_d;

        assign tap = col_q[COL_DLY-1];
    end

    assign pix_out   = pix_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pixel_delay_line.sv
module tb_pixel_delay_line;

    localparam int DW = 24;
    localparam int MW = 16;
    localparam int RD = 2;
    localparam int CD = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    line_w;
    logic          bypass;
    logic          sof;
    logic          pix_valid;
    logic [DW-1:0] pix_in;
    logic [DW-1:0] pix_out;
    logic          out_valid;

    always #5 clk = ~clk;

    pixel_delay_line #(
        .DATA_W  (DW),
        .MAX_W   (MW),
        .ROW_DLY (RD),
        .COL_DLY (CD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_w    (line_w),
        .bypass    (bypass),
        .sof       (sof),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_out   (pix_out),
        .out_valid (out_valid)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: the frame is a list of accepted pixels; output after
    // accept n is frame[n-D] once n >= D.
    logic [DW-1:0] frame [$];
    int            w_m;
    bit            ev;
    bit            ek;
    logic [DW-1:0] ep;

    always @(posedge clk) begin : model
        int n;
        int d;
        if (!rst_n) begin
            frame.delete();
            w_m = MW;
            ev  = 1'b0;
            ep  = '0;
            ek  = 1'b1;
        end else begin
            if (pix_valid) begin
                if (sof) begin
                    frame.delete();
                    w_m = (line_w == 0 || int'(line_w) > MW) ? MW : int'(line_w);
                end
                frame.push_back(pix_in);
            end
            if (bypass) begin
                ev = pix_valid;
                ep = pix_in;
                ek = 1'b1;
            end else if (pix_valid) begin
                n = frame.size() - 1;
                d = RD * w_m + CD;
                if (n >= d) begin
                    ev = 1'b1;
                    ep = frame[n-d];
                    ek = 1'b1;
                end else begin
                    ev = 1'b0;
                    ek = 1'b0;
                end
            end else begin
                ev = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (out_valid !== ev) begin
                failures++;
                $display("FAIL model_out_valid t=%0t actual=%b required=%b", $time, out_valid, ev);
            end
            if (ek) begin
                checks++;
                if (pix_out !== ep) begin
                    failures++;
                    $display("FAIL model_pix_out t=%0t actual=%h required=%h", $time, pix_out, ep);
                end
            end
        end
    end

    task automatic cyc(input bit s, input bit v, input bit b, input bit r, input logic [DW-1:0] p);
        @(negedge clk);
        sof       = s;
        pix_valid = v;
        bypass    = b;
        rst_n     = r;
        pix_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One frame of n accepts with random gaps; a mid-frame line_w change is
    // issued and must be ignored. The output after accept index d must be
    // the frame's first pixel.
    task automatic rand_frame(input logic [4:0] lw, input int n, input int d,
                              input bit ramp, input string tag);
        int            k;
        bit            v;
        logic [DW-1:0] p;
        logic [DW-1:0] first;
        k      = 0;
        first  = '0;
        line_w = lw;
        while (k < n) begin
            v = (k == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            p = (ramp && v) ? DW'(k) : DW'($urandom);
            if (k == 0) first = p;
            if (k == 10) line_w = 5'd5;
            cyc(k == 0, v, 1'b0, 1'b1, p);
            if (v && k == d) begin
                lit({tag, "_valid"}, DW'(out_valid), DW'(1));
                lit({tag, "_first"}, pix_out, first);
            end
            if (v) k++;
        end
    endtask

    initial begin
        bit b_r;
        rst_n = 1'b0; sof = 1'b0; pix_valid = 1'b0; bypass = 1'b0;
        pix_in = '0; line_w = 5'd8;
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk_en = 1'b1;
        lit("reset_valid", DW'(out_valid), DW'(0));
        lit("reset_pix", pix_out, DW'(0));

        // Ramp on continuous accepts, W=8, D=19
        line_w = 5'd8;
        for (int i = 0; i < 64; i++) begin
            cyc(i == 0, 1, 0, 1, DW'(i));
            if (i == 18) lit("t1_idx18_valid", DW'(out_valid), DW'(0));
            if (i == 19) begin
                lit("t1_idx19_valid", DW'(out_valid), DW'(1));
                lit("t1_idx19_pix", pix_out, DW'(0));
            end
            if (i == 20) lit("t1_idx20_pix", pix_out, DW'(1));
        end

        // Same ramp with random gaps
        rand_frame(5'd8, 64, 19, 1'b1, "t2");

        // Mid-frame sof on accept 30 with value 100
        line_w = 5'd8;
        for (int i = 0; i < 55; i++) begin
            cyc(i == 0 || i == 30, 1, 0, 1, (i < 30) ? DW'(i) : DW'(100 + i - 30));
            if (i == 48) lit("t3_idx18_valid", DW'(out_valid), DW'(0));
            if (i == 49) begin
                lit("t3_idx19_valid", DW'(out_valid), DW'(1));
                lit("t3_idx19_pix", pix_out, DW'(100));
            end
        end

        // Bypass burst mid-frame, then back to normal mode
        for (int i = 0; i < 45; i++) begin
            b_r = (i >= 30 && i < 35);
            cyc(i == 0, 1, b_r, 1, b_r ? DW'(24'hA5A5A5) : DW'(i));
            if (i == 30) begin
                lit("t4_byp_pix", pix_out, DW'(24'hA5A5A5));
                lit("t4_byp_valid", DW'(out_valid), DW'(1));
            end
            if (i == 35) begin
                lit("t4_exit_pix", pix_out, DW'(16));
                lit("t4_exit_valid", DW'(out_valid), DW'(1));
            end
        end

        // Reset at accept 40, new frame with sof afterwards
        for (int i = 0; i <= 40; i++) begin
            cyc(i == 0, 1, 0, i != 40, DW'(i));
        end
        lit("t5_rst_pix", pix_out, DW'(0));
        lit("t5_rst_valid", DW'(out_valid), DW'(0));
        for (int i = 0; i < 26; i++) begin
            cyc(i == 0, 1, 0, 1, DW'(200 + i));
            if (i == 18) lit("t5_idx18_valid", DW'(out_valid), DW'(0));
            if (i == 19) lit("t5_idx19_pix", pix_out, DW'(200));
        end

        // Implicit frame after reset: width back to MAX_W, D=35
        cyc(0, 0, 0, 0, '0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 0, 1, DW'(300 + i));
            if (i == 34) lit("t5b_idx34_valid", DW'(out_valid), DW'(0));
            if (i == 35) lit("t5b_idx35_pix", pix_out, DW'(300));
        end

        // Full-width rows, then line_w=0 and an oversize width
        rand_frame(5'd16, 90, 35, 1'b0, "t6_w16");
        rand_frame(5'd0, 90, 35, 1'b0, "t6_w0");
        rand_frame(5'd20, 60, 35, 1'b0, "t6_w20");
        rand_frame(5'd1, 20, 5, 1'b0, "t6_w1");

        // Random mix of everything
        b_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) b_r = ~b_r;
            line_w = 5'($urandom_range(0, 20));
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, b_r,
                $urandom_range(0, 249) != 0, DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
